// File: rtl/shift_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// shift_ctrl_fsm
//
// Sequencing controller for the 32-bit load/shift-right register in the CA
// datapath. It accepts a 16-bit operand and a shift amount on a start/done
// handshake. It then drives the register's load and shift-right enables for
// the required number of cycles and captures the shifted 32-bit value. The
// shift register therefore needs no counter of its own.
//
// State table:
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | waiting for start; operand and shift count captured on accept
//   LOAD     | sr_load high, register takes {operand,16'b0}
//   SHIFT    | sr_shiftrighten high, counter counts down to the last shift
//   CAPTURE  | no enables; result <= sr_q, done pulses next cycle
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   start            request; sampled only while IDLE
//   data_in[15:0]    operand, captured on an accepted start
//   shamt[CNT_W-1:0] number of right shifts, captured on an accepted start
//   sr_q[31:0]       current shift-register value from the datapath
//   sr_load          load enable to the shift register
//   sr_shiftrighten  shift-right enable to the shift register
//   sr_data[15:0]    operand to the shift register (always the operand reg)
//   busy             high while an operation is in flight
//   done             one-cycle completion pulse
//   result[31:0]     captured value, held until the next completion
//
// Build option:
//   SHIFT_CTRL_EARLY_EXIT_EN - when defined, SHIFT stops as soon as sr_q is
//   all zero, because further shifts cannot change the result.
// -----------------------------------------------------------------------------
module shift_ctrl_fsm #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      data_in,
    input  logic [CNT_W-1:0] shamt,
    input  logic [31:0]      sr_q,
    output logic             sr_load,
    output logic             sr_shiftrighten,
    output logic [15:0]      sr_data,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [15:0]      op_q,     op_d;
    logic [31:0]      result_q, result_d;
    logic             done_q,   done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        op_d            = op_q;
        result_d        = result_q;
        done_d          = 1'b0;
        sr_load         = 1'b0;
        sr_shiftrighten = 1'b0;
        busy            = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A start in the done cycle is accepted here, so
                // back-to-back operations need no gap.
                if (start) begin
                    op_d    = data_in;
                    cnt_d   = shamt;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                busy    = 1'b1;
                sr_load = 1'b1;
                state_d = (cnt_q != '0) ? ST_SHIFT : ST_CAPTURE;
            end

            ST_SHIFT: begin
                busy = 1'b1;
`ifdef SHIFT_CTRL_EARLY_EXIT_EN
                // An all-zero register stays zero, so skip the remaining shifts.
                if (sr_q == 32'd0) begin
                    cnt_d   = '0;
                    state_d = ST_CAPTURE;
                end else begin
                    sr_shiftrighten = 1'b1;
                    cnt_d           = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_CAPTURE;
                    end
                end
`else
                sr_shiftrighten = 1'b1;
                cnt_d           = cnt_q - CNT_ONE;
                // A count of one means this is the last shift cycle.
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_CAPTURE;
                end
`endif
            end

            ST_CAPTURE: begin
                busy     = 1'b1;
                result_d = sr_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sr_data = op_q;
    assign done    = done_q;
    assign result  = result_q;

endmodule

// File: tb/tb_shift_ctrl_fsm.sv
module tb_shift_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] sr_q;
    logic        sr_load;
    logic        sr_shiftrighten;
    logic [15:0] sr_data;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] res;
        int          e0;
        int          lat;
        int          shifts;
    } exp_t;

    exp_t exp_q[$];

    int n_shift = 0;
    int n_busy  = 0;
    int n_load  = 0;

    shift_ctrl_fsm #(.CNT_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .data_in         (data_in),
        .shamt           (shamt),
        .sr_q            (sr_q),
        .sr_load         (sr_load),
        .sr_shiftrighten (sr_shiftrighten),
        .sr_data         (sr_data),
        .busy            (busy),
        .done            (done),
        .result          (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model of the datapath shift register (not reset).
    logic [31:0] sr_model = 32'd0;
    always @(posedge clk) begin
        if (sr_load)
            sr_model <= {sr_data, 16'd0};
        else if (sr_shiftrighten)
            sr_model <= {1'b0, sr_model[31:1]};
    end
    assign sr_q = sr_model;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever done is presented.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            n_shift = 0;
            n_busy  = 0;
            n_load  = 0;
        end else begin
            chk("enables_exclusive", {31'd0, sr_load & sr_shiftrighten}, 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result",       result,             e.res);
                    chk("latency",      cyc - e.e0,         e.lat);
                    chk("shift_cycles", n_shift,            e.shifts);
                    chk("busy_cycles",  n_busy,             e.lat);
                    chk("load_cycles",  n_load,             32'd1);
                    chk("busy_in_done", {31'd0, busy},      32'd0);
                end
                n_shift = 0;
                n_busy  = 0;
                n_load  = 0;
            end else begin
                if (sr_shiftrighten) n_shift++;
                if (busy)            n_busy++;
                if (sr_load)         n_load++;
            end
        end
    end

    task automatic push_exp(input logic [31:0] r, input int e0, input int lat, input int sh);
        exp_t e;
        e.res    = r;
        e.e0     = e0;
        e.lat    = lat;
        e.shifts = sh;
        exp_q.push_back(e);
    endtask

    // Issue one operation from idle; garbage inputs afterwards must be ignored.
    task automatic run_op(input logic [15:0] d, input logic [4:0] s,
                          input logic [31:0] r, input int lat, input int sh);
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        shamt   = s;
        push_exp(r, cyc + 1, lat, sh);
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'hDEAD;
        shamt   = 5'd7;
        repeat (lat + 2) @(negedge clk);
    endtask

    initial begin
        int zero_lat;
        int zero_sh;
        int e0;

        rst     = 1'b1;
        start   = 1'b1;
        data_in = 16'hFFFF;
        shamt   = 5'd5;
        repeat (3) @(negedge clk);
        chk("rst_busy",    {31'd0, busy},            32'd0);
        chk("rst_done",    {31'd0, done},            32'd0);
        chk("rst_result",  result,                   32'd0);
        chk("rst_load",    {31'd0, sr_load},         32'd0);
        chk("rst_shift",   {31'd0, sr_shiftrighten}, 32'd0);
        chk("rst_sr_data", {16'd0, sr_data},         32'd0);
        rst   = 1'b0;
        start = 1'b0;

        run_op(16'hABCD, 5'd4,  32'h0ABCD000, 6,  4);
        run_op(16'hABCD, 5'd0,  32'hABCD0000, 2,  0);
        run_op(16'h8000, 5'd31, 32'h00000001, 33, 31);

        // Start held high across an operation; second op accepted in done cycle.
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'h1234;
        shamt   = 5'd3;
        e0      = cyc + 1;
        push_exp(32'h02468000, e0, 5, 3);
        @(negedge clk);
        data_in = 16'hFFFF;
        shamt   = 5'd0;
        while (cyc < e0 + 5) @(negedge clk);
        data_in = 16'h00F0;
        shamt   = 5'd1;
        push_exp(32'h00780000, e0 + 6, 3, 1);
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'h0000;
        shamt   = 5'd0;
        repeat (6) @(negedge clk);

        // Reset during the second SHIFT cycle of a shamt=10 run.
        start   = 1'b1;
        data_in = 16'h5A5A;
        shamt   = 5'd10;
        @(negedge clk);
        start   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy",   {31'd0, busy},            32'd0);
        chk("midrst_done",   {31'd0, done},            32'd0);
        chk("midrst_result", result,                   32'd0);
        chk("midrst_shift",  {31'd0, sr_shiftrighten}, 32'd0);
        chk("midrst_data",   {16'd0, sr_data},         32'd0);
        repeat (15) @(negedge clk);
        run_op(16'hC3C3, 5'd2, 32'h30F0C000, 4, 2);

`ifdef SHIFT_CTRL_EARLY_EXIT_EN
        zero_lat = 3;
        zero_sh  = 0;
`else
        zero_lat = 22;
        zero_sh  = 20;
`endif
        run_op(16'h0000, 5'd20, 32'h00000000, zero_lat, zero_sh);

        repeat (5) @(negedge clk);
        chk("pending_expectations", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_ctrl_fsm.md
# shift_ctrl_fsm

Sequencing controller for the 32-bit load/shift-right register in the CA datapath. It accepts a 16-bit operand and a shift amount through a start/done handshake, drives the register's load and shift-right enables for the required number of cycles, and captures the shifted 32-bit result. It sits between the issuing control unit and the shift register, so the register never needs its own counter.

## Interface
- CNT_W, default 5: width of the shift-amount field and of the internal down-counter; maximum shift is 2^CNT_W-1.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse or level; sampled only while idle.
- data_in  in  16  operand, captured when a start is accepted.
- shamt  in  CNT_W  number of right shifts, captured when a start is accepted.
- sr_q  in  32  current shift-register value, fed back from the datapath.
- sr_load  out  1  load enable to the shift register.
- sr_shiftrighten  out  1  shift-right enable to the shift register.
- sr_data  out  16  operand to the shift register's data_in.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle completion pulse.
- result  out  32  captured shift-register value, held until the next completion.

## Operation
- States: IDLE, LOAD, SHIFT, CAPTURE.
- IDLE, busy=0: when start=1, capture data_in to the operand register and shamt to the counter, then go to LOAD.
- LOAD: sr_load=1, sr_data=operand. The register takes {operand,16'b0} at the end of this cycle. Next state is SHIFT if the counter is non-zero, otherwise CAPTURE.
- SHIFT: sr_shiftrighten=1 and the counter decrements each cycle. Leave for CAPTURE in the cycle the counter equals 1, which is the last shift cycle.
- CAPTURE: no enables asserted. At the end of the cycle, result<=sr_q, done<=1, and the FSM goes to IDLE.
- sr_load and sr_shiftrighten are decoded from state only and are never high together.
- sr_data holds the operand register in every state.
- Expected result is ({data_in,16'b0} >> shamt), zero-filled.
- In any non-IDLE state, start is ignored and operands are not re-captured.
- A start in the IDLE cycle where done=1 is accepted, so back-to-back operations need no gap.
- Reset values: state=IDLE; counter=0; operand=0; result=0; busy=0; done=0; sr_load=0; sr_shiftrighten=0; sr_data=0.
- Reset asserted mid-operation wins over every transition. The next cycle is IDLE with all outputs at reset values and no done pulse. The shift register's own contents are not guaranteed.

## Timing
- Call the edge that samples an accepted start E0.
- LOAD occupies the cycle after E0.
- SHIFT occupies shamt cycles.
- CAPTURE occupies one cycle.
- done and the new result are visible for one cycle starting shamt+2 cycles after E0.
- shamt=0: done visible 2 cycles after E0.
- busy is high from the cycle after E0 through CAPTURE, and low in the done cycle.
- Throughput: one operation per shamt+3 cycles.

## Configuration
- SHIFT_CTRL_EARLY_EXIT_EN defined:
  - In SHIFT, if sr_q==32'b0, deassert sr_shiftrighten in that cycle, clear the counter and go to CAPTURE.
  - Result is identical (zero); latency shortens.
  - The check applies from the first SHIFT cycle.
- SHIFT_CTRL_EARLY_EXIT_EN undefined: SHIFT always runs exactly shamt cycles regardless of sr_q.

## Test plan
- data_in=16'hABCD, shamt=4 -> exactly 4 sr_shiftrighten cycles; done 6 cycles after E0; result=32'h0ABCD000.
- data_in=16'hABCD, shamt=0 -> no shift cycles; done 2 cycles after E0; result=32'hABCD0000.
- data_in=16'h8000, shamt=31 -> result=32'h00000001; busy high 33 cycles.
- Start held high through an operation (5'd3, then 5'd1 applied during done):
  - Start during busy is ignored.
  - The second operation is accepted in the done cycle and completes with its own operands.
- rst asserted in the second SHIFT cycle of a shamt=10 run -> next cycle IDLE; busy=0, result=0, no done pulse; a fresh start then completes normally.
- data_in=0, shamt=20:
  - With SHIFT_CTRL_EARLY_EXIT_EN: zero sr_shiftrighten cycles; done 3 cycles after E0; result=0.
  - Without it: 20 shift cycles; done 22 cycles after E0; result=0.
